uart_rx: RTL
============

# uart_rx

UART receiver: 8N1 frames, LSB first, a fixed baud set by a clock-count parameter. It is the receive-side counterpart of the core's transmitter and sits between the board RXD pin and the core's input FIFO or MMIO register. Each frame is sampled at mid-bit. A good byte is presented with a one-cycle `rx_ready` strobe; a bad stop bit is reported with a one-cycle `ferr` strobe.

## Interface
- `CLK_PER_HALF_BIT`, default 5208: clk cycles per half bit period (H); must be ≥2. Full bit period = 2H.
- `clk`  in  1  system clock.
- `rstn`  in  1  reset: synchronous, active-low.
- `rxd`  in  1  asynchronous serial line; idle high.
- `rdata`  out  8  last correctly framed byte; held until the next good frame.
- `rx_ready`  out  1  one-cycle strobe: `rdata` was updated this cycle.
- `ferr`  out  1  one-cycle strobe: stop bit sampled low; frame discarded.
- `rx_busy`  out  1  high in every state except IDLE.

## Operation
- Input path: `rxd` passes through a 2-FF synchronizer to give `rxd_s`, then a third register gives `rxd_prev`. Reset value of all three is 1.
- Reset values: `rdata`=0, `rx_ready`=0, `ferr`=0, `rx_busy`=0, state=IDLE, counter=0, bit index=0, shift register=0.
- States and transitions:
  - IDLE: when `rxd_s`=0 and `rxd_prev`=1 (falling edge), go to START and clear the counter. A level low with no falling edge (e.g. line held low since reset, or a break) never starts a frame.
  - START: the counter increments each cycle. At counter==H-1, sample `rxd_s`.
    - 0: go to DATA, clear counter and bit index.
    - 1: glitch; return to IDLE with no strobe.
  - DATA: at counter==2H-1, shift right with `rxd_s` into bit 7 (`{rxd_s, sh[7:1]}`), clear counter, increment index. After the 8th sample, go to STOP.
  - STOP: at counter==2H-1, sample `rxd_s`, then go to IDLE.
    - 1: `rdata` <= shift register; `rx_ready` pulses.
    - 0: `ferr` pulses; `rdata` unchanged.
- Counter is 32-bit unsigned. It only counts in START, DATA and STOP; it is held at 0 in IDLE.
- There is no consumer handshake. An unread `rdata` is overwritten by the next good frame (overrun is the consumer's responsibility).
- After a `ferr`, the receiver waits in IDLE for a fresh high→low edge.
- `rstn` low at any point, including mid-frame, aborts the frame. No strobe is emitted, and outputs return to reset values on the next edge.

## Timing
- Let edge k be the first clk rising edge at which the `rxd` pin is sampled 0.
  - START entered at edge k+2.
  - Start bit sampled at edge k+H+2.
  - Data bit i (i=0..7) sampled at edge k+H+2+2H(i+1).
  - Stop bit sampled at edge k+19H+2. `rx_ready`/`ferr` are high for exactly the cycle following that edge.
- `rx_busy` is high from edge k+2 through the edge that re-enters IDLE.
- Earliest next start: a falling edge on the pin anywhere after the stop sample point is accepted. Back-to-back frames at nominal baud are received without loss.
- Tolerance: sampling is centred ±(H-1)/(2H·10) per bit, which is adequate for ±2% baud mismatch.

## Structure
- Shared package `uart_pkg`:
  - state enum `uart_rx_state_t` {IDLE, START, DATA, STOP}.
  - `UART_DATA_BITS`=8.
  - Default `CLK_PER_HALF_BIT` constant, shared with the transmitter.
- One natural sub-module, `sync_2ff`: generic 2-FF synchronizer with a parameterised reset value (1 here). The rest is a single FSM plus counter in `uart_rx`.

## Test plan
- H=4. Send 0x55 with a correct stop bit → `rx_ready` high for 1 cycle at edge k+78, `rdata`=0x55, `ferr`=0, `rx_busy` low the next cycle.
- H=4. Send 0xA3 then 0x0F back-to-back, no idle gap → two `rx_ready` strobes 80 cycles apart, `rdata` 0xA3 then 0x0F.
- H=4. Pull `rxd` low for 2 cycles, then high → no strobe, `rx_busy` returns to 0 by edge k+7, state IDLE.
- H=4. Send 0xFF with a stop bit of 0 → `ferr` pulses once at edge k+78, `rdata` keeps its previous value (0x55), and no new frame starts until `rxd` goes high then low.
- H=4. Assert `rstn` low during data bit 3 of 0x3C, release, then send 0x81 → no strobe for 0x3C, `rdata`=0 after reset, then `rdata`=0x81 with one `rx_ready`.
- `rxd` held low through reset release → no frame until the first high→low transition. Sending 0x00 then yields `rdata`=0x00 with `rx_ready`.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame width and default baud divider.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_rx_state_t;

  localparam int unsigned UART_DATA_BITS        = 8;
  localparam int unsigned UART_CLK_PER_HALF_BIT = 5208;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for a single asynchronous bit, with selectable reset value.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rstn,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, one-cycle rx_ready on a good frame, one-cycle ferr
// on a low stop bit.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_PER_HALF_BIT = UART_CLK_PER_HALF_BIT
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      rxd,
  output logic [UART_DATA_BITS-1:0] rdata,
  output logic                      rx_ready,
  output logic                      ferr,
  output logic                      rx_busy
);

  localparam int unsigned         IDX_W     = $clog2(UART_DATA_BITS);
  localparam logic [31:0]         HALF_LAST = 32'(CLK_PER_HALF_BIT - 1);
  localparam logic [31:0]         FULL_LAST = 32'(2 * CLK_PER_HALF_BIT - 1);
  localparam logic [IDX_W-1:0]    IDX_LAST  = IDX_W'(UART_DATA_BITS - 1);

  logic                      rxd_s;
  logic                      rxd_prev_q;
  logic [1:0]                fill_q;
  logic                      armed_q;

  uart_rx_state_t            state_q, state_d;
  logic [31:0]               cnt_q, cnt_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [UART_DATA_BITS-1:0] sh_q, sh_d;
  logic [UART_DATA_BITS-1:0] rdata_q, rdata_d;
  logic                      rx_ready_q, rx_ready_d;
  logic                      ferr_q, ferr_d;

  sync_2ff #(
    .RST_VAL(1'b1)
  ) u_sync (
    .clk (clk),
    .rstn(rstn),
    .d_i (rxd),
    .q_o (rxd_s)
  );

  // The synchronizer's reset value of 1 would fake a falling edge when the line is low at
  // reset release; armed_q only sets once a real high has come through the synchronizer.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rxd_prev_q <= 1'b1;
      fill_q     <= '0;
      armed_q    <= 1'b0;
    end else begin
      rxd_prev_q <= rxd_s;
      fill_q     <= {fill_q[0], 1'b1};
      if (fill_q[1] && rxd_s) armed_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      sh_q       <= '0;
      rdata_q    <= '0;
      rx_ready_q <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      sh_q       <= sh_d;
      rdata_q    <= rdata_d;
      rx_ready_q <= rx_ready_d;
      ferr_q     <= ferr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    sh_d       = sh_q;
    rdata_d    = rdata_q;
    rx_ready_d = 1'b0;
    ferr_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (armed_q && !rxd_s && rxd_prev_q) state_d = START;
      end
      START: begin
        cnt_d = cnt_q + 32'd1;
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          idx_d = '0;
          state_d = rxd_s ? IDLE : DATA;
        end
      end
      DATA: begin
        cnt_d = cnt_q + 32'd1;
        if (cnt_q == FULL_LAST) begin
          sh_d  = {rxd_s, sh_q[UART_DATA_BITS-1:1]};
          cnt_d = '0;
          idx_d = idx_q + 1'b1;
          if (idx_q == IDX_LAST) state_d = STOP;
        end
      end
      STOP: begin
        cnt_d = cnt_q + 32'd1;
        if (cnt_q == FULL_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (rxd_s) begin
            rdata_d    = sh_q;
            rx_ready_d = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rdata    = rdata_q;
  assign rx_ready = rx_ready_q;
  assign ferr     = ferr_q;
  assign rx_busy  = (state_q != IDLE);

endmodule
